// File: rtl/alu_result_fifo_if.sv
// ---------------------------------------------------------------------------
// alu_result_fifo_if
// Bundles the two valid/ready handshakes of the ALU result FIFO.
//   in_valid  / in_ready  / in_data  / in_tag  : producer -> FIFO
//   out_valid / out_ready / out_data / out_tag : FIFO -> consumer
// Modports:
//   slave  : the FIFO's view (accepts on the in_* side, offers on the out_* side)
//   master : the environment's view (producer and consumer combined)
// ---------------------------------------------------------------------------
interface alu_result_fifo_if #(
  parameter int DATA_W = 10,
  parameter int TAG_W  = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/alu_result_fifo.sv
// ---------------------------------------------------------------------------
// alu_result_fifo
// Output buffer for the 5-bit signed ALU. Each accepted result (DATA_W bits)
// is stored with its op tag (TAG_W bits) in a DEPTH-entry FIFO and released
// in order. Per-op saturating counters record how many results of each op
// were accepted.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (flushes FIFO and counters)
//   bus        alu_result_fifo_if.slave: in_* producer side, out_* consumer side
//   count      current occupancy, 0..DEPTH
//   full       count == DEPTH (in_ready is its complement)
//   empty      count == 0     (out_valid is its complement)
//   clr_stats  synchronous clear of all op counters, wins over a same-cycle push
//   op_cnt     {cnt11, cnt10, cnt01, cnt00}, CNT_W bits each
// ---------------------------------------------------------------------------
module alu_result_fifo #(
  parameter int DATA_W = 10,
  parameter int TAG_W  = 2,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_result_fifo_if.slave         bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  input  logic                     clr_stats,
  output logic [4*CNT_W-1:0]       op_cnt
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int OCC_W   = PTR_W + 1;
  localparam int NUM_OPS = 4;

  localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] STAT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] STAT_ONE = CNT_W'(1);

  // Storage; data and tag are kept side by side so the head is one read.
  logic [DATA_W-1:0] mem_data_r [DEPTH];
  logic [TAG_W-1:0]  mem_tag_r  [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [OCC_W-1:0]  count_r;
  logic [OCC_W-1:0]  count_nxt_s;
  logic              full_r;
  logic              empty_r;
  logic              push_s;
  logic              pop_s;

  logic [CNT_W-1:0]   stat_r [NUM_OPS];
  logic [4*CNT_W-1:0] op_cnt_s;

  // Handshake outputs come from registered flags only, so in_ready never
  // looks at in_valid and out_valid never looks at out_ready.
  assign bus.in_ready  = ~full_r;
  assign bus.out_valid = ~empty_r;
  assign bus.out_data  = mem_data_r[rd_ptr_r];
  assign bus.out_tag   = mem_tag_r[rd_ptr_r];

  assign push_s = bus.in_valid & ~full_r;
  assign pop_s  = bus.out_ready & ~empty_r;

  assign count  = count_r;
  assign full   = full_r;
  assign empty  = empty_r;
  assign op_cnt = op_cnt_s;

  // Next occupancy: push and pop together leave it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + OCC_ONE;
      2'b01:   count_nxt_s = count_r - OCC_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Occupancy, pointers and the full/empty flags derived from next occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r  <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == DEPTH_C);
      empty_r <= (count_nxt_s == '0);
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Entry storage; cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_r[i] <= '0;
        mem_tag_r[i]  <= '0;
      end
    end else if (push_s) begin
      mem_data_r[wr_ptr_r] <= bus.in_data;
      mem_tag_r[wr_ptr_r]  <= bus.in_tag;
    end
  end

  // Per-op saturating counters of accepted results; clr_stats wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OPS; i++) begin
        stat_r[i] <= '0;
      end
    end else if (clr_stats) begin
      for (int i = 0; i < NUM_OPS; i++) begin
        stat_r[i] <= '0;
      end
    end else if (push_s) begin
      for (int i = 0; i < NUM_OPS; i++) begin
        if ((bus.in_tag == TAG_W'(i)) && (stat_r[i] != STAT_MAX)) begin
          stat_r[i] <= stat_r[i] + STAT_ONE;
        end
      end
    end
  end

  // Pack counters with op 00 in the least significant slot.
  always_comb begin
    op_cnt_s = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      op_cnt_s[i*CNT_W +: CNT_W] = stat_r[i];
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// ---------------------------------------------------------------------------
// tb_alu_result_fifo
// Directed bench for alu_result_fifo. Stimulus pushes hand-computed expected
// {data, tag} entries into a scoreboard queue; a monitor running alongside
// pops and compares whenever the DUT completes an output transfer.
// ---------------------------------------------------------------------------
module tb_alu_result_fifo;

  localparam int DATA_W = 10;
  localparam int TAG_W  = 2;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 8;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr_stats = 1'b0;
  logic [2:0]    count;
  logic          full;
  logic          empty;
  logic [31:0]   op_cnt;

  entry_t sb[$];
  int     n_checks = 0;
  int     n_fail = 0;

  logic [DATA_W-1:0] t2_data [4] = '{10'h005, 10'h3FF, 10'h019, 10'h004};
  logic [TAG_W-1:0]  t2_tag  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};

  alu_result_fifo_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  alu_result_fifo #(
    .DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .count(count),
    .full(full),
    .empty(empty),
    .clr_stats(clr_stats),
    .op_cnt(op_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_tag   = t;
  endtask

  task automatic push_exp(input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t);
    entry_t e;
    e.data = d;
    e.tag  = t;
    sb.push_back(e);
  endtask

  // Steps until empty, bounded; an expired bound shows up as a failed check.
  task automatic wait_empty(input int budget);
    int k;
    k = 0;
    while (empty !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    chk("drain_empty", 32'(empty), 32'd1);
  endtask

  // Compares every completed output transfer against the scoreboard head.
  task automatic monitor();
    entry_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow: got pop of 0x%0h, expected no transfer", bus.out_data);
        end else begin
          e = sb.pop_front();
          chk("pop_data", 32'(bus.out_data), 32'(e.data));
          chk("pop_tag", 32'(bus.out_tag), 32'(e.tag));
        end
      end
    end
  endtask

  initial begin
    drive(1'b0, '0, '0);
    bus.out_ready = 1'b0;
    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
      end
    join_none

    // 1: reset with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      drive(1'($urandom), 10'($urandom), 2'($urandom));
      bus.out_ready = 1'($urandom);
      clr_stats     = 1'($urandom);
    end
    #2;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_op_cnt", op_cnt, 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
    drive(1'b0, '0, '0);
    bus.out_ready = 1'b0;
    clr_stats = 1'b0;
    #1;
    rst_n = 1'b1;
    step();

    // 2: fill back-to-back, then drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, t2_data[i], t2_tag[i]);
      push_exp(t2_data[i], t2_tag[i]);
      if (i == 0) begin
        #1;
        chk("no_fallthrough", 32'(bus.out_valid), 32'd0);
      end
      step();
      if (i == 0) begin
        chk("first_visible_valid", 32'(bus.out_valid), 32'd1);
        chk("first_visible_data", 32'(bus.out_data), 32'h005);
      end
    end
    drive(1'b0, '0, '0);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
    chk("fill_op_cnt", op_cnt, 32'h01010101);
    bus.out_ready = 1'b1;
    wait_empty(10);
    bus.out_ready = 1'b0;
    chk("drain_count", 32'(count), 32'd0);
    chk("sb_empty_fill", 32'(sb.size()), 32'd0);

    // 3: full stall, one pop lets the held push in
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 10'h011 + 10'(i), 2'b00);
      push_exp(10'h011 + 10'(i), 2'b00);
      step();
    end
    drive(1'b1, 10'h2AA, 2'b01);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_count", 32'(count), 32'd4);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    push_exp(10'h2AA, 2'b01);
    bus.out_ready = 1'b1;
    step();
    chk("stall_pop_count", 32'(count), 32'd3);
    chk("stall_pop_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
    step();
    chk("stall_accept_count", 32'(count), 32'd4);
    chk("stall_accept_full", 32'(full), 32'd1);
    drive(1'b0, '0, '0);
    bus.out_ready = 1'b1;
    wait_empty(10);
    bus.out_ready = 1'b0;

    // 4: simultaneous push/pop at count=2, pointers wrap
    drive(1'b1, 10'h100, 2'b10);
    push_exp(10'h100, 2'b10);
    step();
    drive(1'b1, 10'h101, 2'b10);
    push_exp(10'h101, 2'b10);
    step();
    chk("pp_start_count", 32'(count), 32'd2);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 10'h102 + 10'(i), 2'(i));
      push_exp(10'h102 + 10'(i), 2'(i));
      step();
      chk("pp_count", 32'(count), 32'd2);
    end
    drive(1'b0, '0, '0);
    wait_empty(10);
    bus.out_ready = 1'b0;

    // 5: statistics saturation and clear priority
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    chk("clr_op_cnt", op_cnt, 32'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 10'(i), 2'b10);
      push_exp(10'(i), 2'b10);
      step();
      if (i == 254) begin
        chk("sat_reach_255", 32'(op_cnt[23:16]), 32'd255);
      end
    end
    drive(1'b1, 10'h1F0, 2'b11);
    push_exp(10'h1F0, 2'b11);
    step();
    drive(1'b0, '0, '0);
    chk("sat_op_cnt", op_cnt, 32'h01FF0000);
    wait_empty(10);
    drive(1'b1, 10'h055, 2'b00);
    push_exp(10'h055, 2'b00);
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    drive(1'b0, '0, '0);
    chk("clr_push_op_cnt", op_cnt, 32'd0);
    chk("clr_keeps_entry", 32'(count), 32'd1);
    wait_empty(10);
    bus.out_ready = 1'b0;

    // 6: asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 10'h0A1 + 10'(i), 2'b01);
      push_exp(10'h0A1 + 10'(i), 2'b01);
      step();
    end
    drive(1'b0, '0, '0);
    chk("mid_count", 32'(count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_empty", 32'(empty), 32'd1);
    chk("async_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_count", 32'(count), 32'd0);
    chk("async_op_cnt", op_cnt, 32'd0);
    sb.delete();
    #2;
    rst_n = 1'b1;
    step();
    drive(1'b1, 10'h1C3, 2'b10);
    push_exp(10'h1C3, 2'b10);
    step();
    drive(1'b0, '0, '0);
    chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
    chk("post_rst_data", 32'(bus.out_data), 32'h1C3);
    chk("post_rst_tag", 32'(bus.out_tag), 32'd2);
    bus.out_ready = 1'b1;
    wait_empty(10);
    bus.out_ready = 1'b0;
    step();
    chk("sb_empty_final", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
